instruction_fetch: RTL

Front end of the pipeline: owns the program counter, drives the word address into `instruction_memory`, collects the synchronous-read instruction word one cycle later and presents it, with its PC, to the decode stage through a 2-entry fetch buffer under a valid/ready handshake. Accepts redirects (branch/jump/trap) that flush everything in flight and restart fetch at a new PC. Sustains one instruction per cycle when decode never stalls.

---
 rtl/instruction_fetch.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//
// Pipeline front end. Owns the program counter, drives the word address into
// the synchronous-read instruction memory, captures the returned word one
// cycle later and hands {pc, instr} to decode through a 2-entry FIFO under a
// valid/ready handshake. A redirect flushes everything in flight and restarts
// fetch at the new target. One instruction per cycle when decode never stalls.
//
// Optional feature macro: IFETCH_MISALIGN_CHK_EN
//   defined   : a redirect to a non-word-aligned target raises the sticky
//               fetch_fault flag, loads pc unmodified and stops all issue.
//   undefined : fetch_fault is tied low and redirect targets are word-aligned
//               by clearing bits [1:0].
//
// Ports
//   clk             in   rising-edge clock
//   rst             in   asynchronous active-high reset
//   redirect_valid  in   restart fetch at redirect_pc (highest priority)
//   redirect_pc     in   byte address of the new fetch target
//   imem_addr       out  word index for the instruction memory ({2'b00, pc[63:2]})
//   imem_instr      in   memory read data, valid the cycle after the address
//   out_valid       out  FIFO head holds a fetched instruction
//   out_ready       in   decode accepts the head this cycle
//   out_pc          out  byte PC of the head instruction
//   out_instr       out  head instruction word
//   fetch_fault     out  sticky misaligned-redirect flag
// -----------------------------------------------------------------------------
module instruction_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr,
  output logic        fetch_fault
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [63:0] r_pc;
  logic        r_inflight;
  logic [63:0] r_inflight_pc;

  logic [63:0] r_fifo_pc    [2];
  logic [31:0] r_fifo_instr [2];
  logic        r_rd_ptr;
  logic        r_wr_ptr;
  logic [1:0]  r_count;

  // ---------------------------------------------------------------------------
  // Control
  // ---------------------------------------------------------------------------
  logic        w_pop;
  logic        w_push;
  logic        w_issue;
  logic [2:0]  w_occupancy;
  logic        w_fault;
  logic [63:0] w_redirect_target;

  assign out_valid = (r_count != 2'd0);
  assign w_pop     = out_valid & out_ready;

  // Slots committed after this edge: buffered + in flight - leaving. Counting
  // the pop lets issue resume on the very edge decode drains a full FIFO.
  // A pop implies count >= 1, so the subtraction never underflows.
  assign w_occupancy = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};

  assign w_issue = !redirect_valid && !w_fault && (w_occupancy < 3'd2);

  // A response is only kept if no redirect flushes it on arrival.
  assign w_push = r_inflight && !redirect_valid;

  assign imem_addr = {2'b00, r_pc[63:2]};

`ifdef IFETCH_MISALIGN_CHK_EN
  logic r_fetch_fault;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_fault <= 1'b0;
    end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
      r_fetch_fault <= 1'b1;
    end
  end

  assign w_fault           = r_fetch_fault;
  assign w_redirect_target = redirect_pc;
`else
  logic w_unused_redirect_lsb;

  assign w_unused_redirect_lsb = ^redirect_pc[1:0];
  assign w_fault               = 1'b0;
  assign w_redirect_target     = {redirect_pc[63:2], 2'b00};
`endif

  assign fetch_fault = w_fault;

  // ---------------------------------------------------------------------------
  // Program counter and in-flight request
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_pc <= w_redirect_target;
    end else if (w_issue) begin
      r_pc <= r_pc + 64'd4;
    end
  end

  // Issue is already suppressed during a redirect, so this also drops the
  // outstanding request on a flush; its data returns next cycle and is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inflight <= 1'b0;
    end else if (redirect_valid) begin
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inflight_pc <= 64'd0;
    end else if (w_issue) begin
      r_inflight_pc <= r_pc;
    end
  end

  // ---------------------------------------------------------------------------
  // 2-entry fetch FIFO
  // The issue rule keeps count + inflight <= 2, so a push never finds it full.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fifo_pc[0]    <= 64'd0;
      r_fifo_pc[1]    <= 64'd0;
      r_fifo_instr[0] <= 32'd0;
      r_fifo_instr[1] <= 32'd0;
    end else if (w_push) begin
      r_fifo_pc[r_wr_ptr]    <= r_inflight_pc;
      r_fifo_instr[r_wr_ptr] <= imem_instr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (redirect_valid) begin
      // A pop on this edge still completes: decode already owns that entry.
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign out_pc    = r_fifo_pc[r_rd_ptr];
  assign out_instr = r_fifo_instr[r_rd_ptr];

endmodule
